// File: rtl/ysyx_24100029_icache_line_pkg.sv
// Shared definitions for the line-based instruction cache: FSM states, AXI constants
// and the sticky-response merge used while a refill burst is in flight.
package ysyx_24100029_icache_line_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_REFILL_AR = 3'd2,
        ST_REFILL_R  = 3'd3,
        ST_BYPASS_AR = 3'd4,
        ST_BYPASS_R  = 3'd5,
        ST_RESP      = 3'd6
    } icache_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    // The first non-OKAY beat response of a burst is kept; later beats cannot clear it.
    function automatic logic [1:0] resp_merge(input logic [1:0] sticky, input logic [1:0] beat);
        return (sticky != RESP_OKAY) ? sticky : beat;
    endfunction

endpackage

// File: rtl/ysyx_24100029_icache_array.sv
// Storage for the instruction cache: data words, per-line tags and a valid vector
// that can be cleared in a single cycle. Writes are registered, reads are combinational.
module ysyx_24100029_icache_array #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_W     = $clog2(SETS),
    localparam int WORD_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [IDX_W-1:0]      rd_idx,
    input  logic [WORD_W-1:0]     rd_word,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_valid,
    input  logic                  data_we,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [WORD_W-1:0]     wr_word,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  line_we,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic                  line_valid
);

    logic [DATA_WIDTH-1:0] data_mem [SETS][LINE_WORDS];
    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [SETS-1:0]       valid_q;

    always_ff @(posedge clock) begin
        if (data_we) begin
            data_mem[wr_idx][wr_word] <= wr_data;
        end
        if (line_we) begin
            tag_mem[wr_idx] <= line_tag;
        end
    end

    // Flush takes priority so a fence can never leave a stale line marked valid.
    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid_q[gi] <= 1'b0;
                end else if (flush) begin
                    valid_q[gi] <= 1'b0;
                end else if (line_we && (wr_idx == IDX_W'(gi))) begin
                    valid_q[gi] <= line_valid;
                end
            end
        end
    endgenerate

    assign rd_data  = data_mem[rd_idx][rd_word];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/ysyx_24100029_icache_line.sv
// Direct-mapped read-only I-cache with multi-word lines between IFU and AXI xbar.
// Optional feature macro: ICACHE_PERF_EN adds hit/miss/bypass counters.
module ysyx_24100029_icache_line
    import ysyx_24100029_icache_line_pkg::*;
#(
    parameter int              ADDR_WIDTH    = 32,
    parameter int              DATA_WIDTH    = 32,
    parameter int              LINE_WORDS    = 4,
    parameter int              SETS          = 16,
    parameter logic [ADDR_WIDTH-1:0] UNCACHED_BASE = 32'h0f00_0000,
    parameter logic [ADDR_WIDTH-1:0] UNCACHED_MASK = 32'hff00_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    input  logic [ADDR_WIDTH-1:0] ifu_araddr,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic [1:0]            ifu_rresp,
    output logic                  ifu_rlast,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    output logic [ADDR_WIDTH-1:0] mem_araddr,
    output logic [7:0]            mem_arlen,
    output logic [2:0]            mem_arsize,
    output logic [1:0]            mem_arburst,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [1:0]            mem_rresp,
    input  logic                  mem_rlast,
    input  logic                  fence_i
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]           perf_hit,
    output logic [31:0]           perf_miss,
    output logic [31:0]           perf_bypass
`endif
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int OFF_BITS  = WORD_BITS + 2;
    localparam int IDX_W     = $clog2(SETS);
    localparam int TAG_W     = ADDR_WIDTH - OFF_BITS - IDX_W;
    localparam int WORD_W    = (LINE_WORDS > 1) ? WORD_BITS : 1;
    localparam logic [7:0] REFILL_LEN = 8'(LINE_WORDS - 1);

    icache_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [WORD_W-1:0]     beat_q, beat_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  fence_pend_q, fence_pend_d;

    logic                  ar_hs;
    logic                  req_uncached;
    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [WORD_W-1:0]     req_word;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic                  lookup_hit;
    logic                  flush;
    logic [1:0]            merged_resp;

    logic [DATA_WIDTH-1:0] arr_data;
    logic [TAG_W-1:0]      arr_tag;
    logic                  arr_valid;
    logic                  data_we;
    logic                  line_we;
    logic                  line_valid;

    assign req_idx   = req_addr_q[OFF_BITS +: IDX_W];
    assign req_tag   = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign line_addr = {req_addr_q[ADDR_WIDTH-1:OFF_BITS], OFF_BITS'(0)};

    generate
        if (LINE_WORDS > 1) begin : g_word_sel
            assign req_word = req_addr_q[2 +: WORD_W];
        end else begin : g_word_zero
            assign req_word = '0;
        end
    endgenerate

    // A fence seen this cycle or still pending blocks new requests until the flush lands.
    assign ifu_arready  = ~reset & (state_q == ST_IDLE) & ~fence_pend_q & ~fence_i;
    assign ar_hs        = ifu_arvalid & ifu_arready;
    assign req_uncached = (ifu_araddr & UNCACHED_MASK) == UNCACHED_BASE;
    assign lookup_hit   = arr_valid & (arr_tag == req_tag);
    assign merged_resp  = resp_merge(resp_q, mem_rresp);

    assign flush        = (state_q == ST_IDLE) & (fence_i | fence_pend_q);
    assign fence_pend_d = (state_q != ST_IDLE) & (fence_pend_q | fence_i);

    assign ifu_rdata   = rdata_q;
    assign ifu_rresp   = resp_q;
    assign ifu_rlast   = ifu_rvalid;
    assign mem_arsize  = AXI_SIZE_4B;
    assign mem_arburst = AXI_BURST_INCR;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        ifu_rvalid  = 1'b0;
        mem_arvalid = 1'b0;
        mem_araddr  = '0;
        mem_arlen   = 8'd0;
        mem_rready  = 1'b0;
        data_we     = 1'b0;
        line_we     = 1'b0;
        line_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_d = req_uncached ? ST_BYPASS_AR : ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lookup_hit) begin
                    rdata_d = arr_data;
                    resp_d  = RESP_OKAY;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_REFILL_AR;
                end
            end
            ST_REFILL_AR: begin
                mem_arvalid = 1'b1;
                mem_araddr  = line_addr;
                mem_arlen   = REFILL_LEN;
                if (mem_arready) begin
                    beat_d  = '0;
                    resp_d  = RESP_OKAY;
                    state_d = ST_REFILL_R;
                end
            end
            ST_REFILL_R: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    resp_d  = merged_resp;
                    // The requested word is kept aside so RESP never re-reads the array.
                    if (beat_q == req_word) begin
                        rdata_d = mem_rdata;
                    end
                    if (mem_rlast) begin
                        line_we    = 1'b1;
                        line_valid = (merged_resp == RESP_OKAY);
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_BYPASS_AR: begin
                mem_arvalid = 1'b1;
                mem_araddr  = req_addr_q;
                if (mem_arready) begin
                    state_d = ST_BYPASS_R;
                end
            end
            ST_BYPASS_R: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    resp_d  = mem_rresp;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                ifu_rvalid = 1'b1;
                if (ifu_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_addr_q   <= '0;
            beat_q       <= '0;
            rdata_q      <= '0;
            resp_q       <= RESP_OKAY;
            fence_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            fence_pend_q <= fence_pend_d;
            if (ar_hs) begin
                req_addr_q <= ifu_araddr;
            end
        end
    end

    ysyx_24100029_icache_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .rd_idx     (req_idx),
        .rd_word    (req_word),
        .rd_data    (arr_data),
        .rd_tag     (arr_tag),
        .rd_valid   (arr_valid),
        .data_we    (data_we),
        .wr_idx     (req_idx),
        .wr_word    (beat_q),
        .wr_data    (mem_rdata),
        .line_we    (line_we),
        .line_tag   (req_tag),
        .line_valid (line_valid)
    );

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_q, perf_miss_q, perf_bypass_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_hit_q    <= 32'd0;
            perf_miss_q   <= 32'd0;
            perf_bypass_q <= 32'd0;
        end else begin
            if (state_q == ST_LOOKUP && lookup_hit) begin
                perf_hit_q <= perf_hit_q + 32'd1;
            end
            if (state_q == ST_LOOKUP && !lookup_hit) begin
                perf_miss_q <= perf_miss_q + 32'd1;
            end
            if (ar_hs && req_uncached) begin
                perf_bypass_q <= perf_bypass_q + 32'd1;
            end
        end
    end

    assign perf_hit    = perf_hit_q;
    assign perf_miss   = perf_miss_q;
    assign perf_bypass = perf_bypass_q;
`endif

endmodule

// File: tb/tb_ysyx_24100029_icache_line.sv
// Scoreboard bench for the line I-cache: a driver queues expected responses, a monitor
// checks IFU responses, and a memory model checks refill/bypass requests and returns data.
module tb_ysyx_24100029_icache_line;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_arvalid = 1'b0;
    logic        ifu_arready;
    logic [31:0] ifu_araddr = 32'd0;
    logic        ifu_rvalid;
    logic        ifu_rready = 1'b1;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rlast;
    logic        mem_arvalid;
    logic        mem_arready = 1'b0;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst;
    logic        mem_rvalid = 1'b0;
    logic        mem_rready;
    logic [31:0] mem_rdata = 32'd0;
    logic [1:0]  mem_rresp = 2'b00;
    logic        mem_rlast = 1'b0;
    logic        fence_i = 1'b0;

    ysyx_24100029_icache_line dut (
        .clock       (clock),
        .reset       (reset),
        .ifu_arvalid (ifu_arvalid),
        .ifu_arready (ifu_arready),
        .ifu_araddr  (ifu_araddr),
        .ifu_rvalid  (ifu_rvalid),
        .ifu_rready  (ifu_rready),
        .ifu_rdata   (ifu_rdata),
        .ifu_rresp   (ifu_rresp),
        .ifu_rlast   (ifu_rlast),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_araddr  (mem_araddr),
        .mem_arlen   (mem_arlen),
        .mem_arsize  (mem_arsize),
        .mem_arburst (mem_arburst),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .mem_rlast   (mem_rlast),
        .fence_i     (fence_i)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        bit          miss;
        int          ar_before;
        int          hs_cyc;
        int          lat;
        int          stall;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_exp_t;

    exp_t    sb_q[$];
    ar_exp_t ar_q[$];
    int      ar_cnt   = 0;
    int      err_beat = -1;
    int      total    = 0;
    int      passed   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Memory model: data at byte address A is A + 0x1000_0000.
    initial begin
        logic [31:0] cur_addr;
        logic [7:0]  cur_len;
        bit          aborted;
        int          tries;
        ar_exp_t     ae;
        forever begin
            @(negedge clock);
            if (!reset && mem_arvalid) begin
                cur_addr = mem_araddr;
                cur_len  = mem_arlen;
                ar_cnt++;
                if (ar_q.size() == 0) begin
                    fail($sformatf("unexpected_mem_ar addr=%h", cur_addr));
                end else begin
                    ae = ar_q.pop_front();
                    check("mem_araddr", cur_addr, ae.addr);
                    check("mem_arlen", {24'd0, cur_len}, {24'd0, ae.len});
                end
                mem_arready = 1'b1;
                @(negedge clock);
                mem_arready = 1'b0;
                repeat (2) @(negedge clock);
                aborted = 1'b0;
                for (int b = 0; b <= int'(cur_len) && !aborted; b++) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = cur_addr + 32'(b * 4) + 32'h1000_0000;
                    mem_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
                    mem_rlast  = (b == int'(cur_len));
                    tries = 0;
                    forever begin
                        #1;
                        if (reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (mem_rready) begin
                            @(negedge clock);
                            break;
                        end
                        @(negedge clock);
                        tries++;
                        if (tries > 50) begin
                            fail("mem_rready_timeout");
                            aborted = 1'b1;
                            break;
                        end
                    end
                end
                mem_rvalid = 1'b0;
                mem_rlast  = 1'b0;
                mem_rresp  = 2'b00;
                mem_rdata  = 32'd0;
            end
        end
    end

    // Monitor: compares each IFU response against the head of the scoreboard.
    initial begin
        bit          in_resp = 1'b0;
        int          stalled = 0;
        int          first_cyc = 0;
        logic [31:0] hold_d = 32'd0;
        logic [1:0]  hold_r = 2'b00;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (reset) begin
                sb_q.delete();
                in_resp    = 1'b0;
                stalled    = 0;
                ifu_rready = 1'b1;
                continue;
            end
            if (!ifu_rvalid) continue;
            if (!in_resp) begin
                in_resp   = 1'b1;
                first_cyc = cyc;
                hold_d    = ifu_rdata;
                hold_r    = ifu_rresp;
                stalled   = 0;
            end else begin
                check("stall_rdata_stable", ifu_rdata, hold_d);
                check("stall_rresp_stable", {30'd0, ifu_rresp}, {30'd0, hold_r});
            end
            if (sb_q.size() == 0) begin
                fail($sformatf("unexpected_ifu_resp rdata=%h", ifu_rdata));
                ifu_rready = 1'b1;
                in_resp    = 1'b0;
                continue;
            end
            e = sb_q[0];
            if (stalled < e.stall) begin
                ifu_rready = 1'b0;
                stalled++;
            end else begin
                ifu_rready = 1'b1;
                void'(sb_q.pop_front());
                in_resp = 1'b0;
                check($sformatf("rdata@%h", e.addr), ifu_rdata, e.data);
                check($sformatf("rresp@%h", e.addr), {30'd0, ifu_rresp}, {30'd0, e.resp});
                check($sformatf("rlast@%h", e.addr), {31'd0, ifu_rlast}, 32'd1);
                check($sformatf("mem_reads@%h", e.addr), 32'(ar_cnt - e.ar_before),
                      e.miss ? 32'd1 : 32'd0);
                if (e.lat >= 0)
                    check($sformatf("latency@%h", e.addr), 32'(first_cyc - e.hs_cyc), 32'(e.lat));
                $display("txn addr=%h rdata=%h rresp=%0d miss=%0d", e.addr, ifu_rdata, ifu_rresp, e.miss);
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                         input bit miss, input logic [31:0] ar_addr, input logic [7:0] ar_len,
                         input int lat, input int stall, input bit fence_same);
        bit   ok = 1'b0;
        exp_t e;
        @(negedge clock);
        ifu_arvalid = 1'b1;
        ifu_araddr  = addr;
        if (fence_same) fence_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                @(negedge clock);
                fence_i = 1'b0;
            end
            #1;
            if (i == 0 && fence_same) check("fence_wins_arready", {31'd0, ifu_arready}, 32'd0);
            if (ifu_arready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail($sformatf("arready_timeout@%h", addr));
        end else begin
            e.addr = addr; e.data = data; e.resp = resp; e.miss = miss;
            e.ar_before = ar_cnt; e.hs_cyc = cyc; e.lat = lat; e.stall = stall;
            sb_q.push_back(e);
            if (miss) ar_q.push_back('{addr: ar_addr, len: ar_len});
        end
        @(negedge clock);
        ifu_arvalid = 1'b0;
        fence_i     = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (sb_q.size() == 0) return;
        end
        fail("response_timeout");
        sb_q.delete();
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                         input bit miss, input logic [31:0] ar_addr, input logic [7:0] ar_len,
                         input int lat);
        issue(addr, data, resp, miss, ar_addr, ar_len, lat, 0, 1'b0);
        wait_done();
    endtask

    task automatic wait_first_beat();
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            #1;
            if (mem_rvalid && mem_rready) return;
        end
        fail("first_beat_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ifu_arready"}, {31'd0, ifu_arready}, 32'd0);
        check({tag, "_ifu_rvalid"},  {31'd0, ifu_rvalid}, 32'd0);
        check({tag, "_ifu_rdata"},   ifu_rdata, 32'd0);
        check({tag, "_ifu_rresp"},   {30'd0, ifu_rresp}, 32'd0);
        check({tag, "_ifu_rlast"},   {31'd0, ifu_rlast}, 32'd0);
        check({tag, "_mem_arvalid"}, {31'd0, mem_arvalid}, 32'd0);
        check({tag, "_mem_araddr"},  mem_araddr, 32'd0);
        check({tag, "_mem_arlen"},   {24'd0, mem_arlen}, 32'd0);
        check({tag, "_mem_rready"},  {31'd0, mem_rready}, 32'd0);
        check({tag, "_mem_arsize"},  {29'd0, mem_arsize}, 32'd2);
        check({tag, "_mem_arburst"}, {30'd0, mem_arburst}, 32'd1);
    endtask

    initial begin
        @(negedge clock);
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Cold miss, then hits in the same line
        fetch(32'h3000_0000, 32'h4000_0000, 2'b00, 1, 32'h3000_0000, 8'd3, -1);
        fetch(32'h3000_000c, 32'h4000_000c, 2'b00, 0, 32'h0, 8'd0, 2);
        fetch(32'h3000_0004, 32'h4000_0004, 2'b00, 0, 32'h0, 8'd0, 2);

        // Conflict on index 0 evicts, original line misses again
        fetch(32'h3000_0100, 32'h4000_0100, 2'b00, 1, 32'h3000_0100, 8'd3, -1);
        fetch(32'h3000_0008, 32'h4000_0008, 2'b00, 1, 32'h3000_0000, 8'd3, -1);

        // Uncached region: single beat, never cached
        fetch(32'h0f00_0010, 32'h1f00_0010, 2'b00, 1, 32'h0f00_0010, 8'd0, -1);
        fetch(32'h0f00_0010, 32'h1f00_0010, 2'b00, 1, 32'h0f00_0010, 8'd0, -1);

        // fence_i during a refill: response still delivered, everything invalid afterwards
        issue(32'h3000_0044, 32'h4000_0044, 2'b00, 1, 32'h3000_0040, 8'd3, -1, 0, 1'b0);
        wait_first_beat();
        fence_i = 1'b1;
        @(negedge clock);
        fence_i = 1'b0;
        wait_done();
        fetch(32'h3000_0040, 32'h4000_0040, 2'b00, 1, 32'h3000_0040, 8'd3, -1);
        fetch(32'h3000_0008, 32'h4000_0008, 2'b00, 1, 32'h3000_0000, 8'd3, -1);
        fetch(32'h3000_000c, 32'h4000_000c, 2'b00, 0, 32'h0, 8'd0, 2);

        // fence_i together with arvalid in IDLE: fence wins, request then misses
        issue(32'h3000_0004, 32'h4000_0004, 2'b00, 1, 32'h3000_0000, 8'd3, -1, 0, 1'b1);
        wait_done();

        // Error on beat 2: sticky SLVERR, line left invalid
        err_beat = 2;
        fetch(32'h3000_0200, 32'h4000_0200, 2'b10, 1, 32'h3000_0200, 8'd3, -1);
        err_beat = -1;
        fetch(32'h3000_0200, 32'h4000_0200, 2'b00, 1, 32'h3000_0200, 8'd3, -1);

        // IFU back-pressure for 5 cycles on a hit
        issue(32'h3000_0204, 32'h4000_0204, 2'b00, 0, 32'h0, 8'd0, 2, 5, 1'b0);
        wait_done();

        // Reset in the middle of a refill
        issue(32'h3000_0300, 32'h4000_0300, 2'b00, 1, 32'h3000_0300, 8'd3, -1, 0, 1'b0);
        wait_first_beat();
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        fetch(32'h3000_0204, 32'h4000_0204, 2'b00, 1, 32'h3000_0200, 8'd3, -1);
        fetch(32'h3000_0044, 32'h4000_0044, 2'b00, 1, 32'h3000_0040, 8'd3, -1);

        repeat (5) @(negedge clock);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("mem_ar_drained", 32'(ar_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
